hermitian_rmv_bram_writer: RTL and testbench

//  Upstream stage of the Hermitian-remover output buffer: consumes one FFT frame per
//  AXI-Stream burst, counts bin index, and writes only the non-redundant bins into the
//  336x16 output buffer. All other bins are discarded. Single-buffered: after a frame

---
 rtl/hermitian_rmv_bram_writer.sv | 159 +++++++++++++++
 tb/tb_hermitian_rmv_bram_writer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hermitian_rmv_bram_writer.sv
// Hermitian-remover write side: counts FFT bins per frame and writes the kept bins into the
// output buffer, then holds the buffer until released. Optional tlast checking: HERMRMV_TLAST_CHECK_EN.
module hermitian_rmv_bram_writer #(
  parameter int FFT_LEN    = 672,
  parameter int KEEP_FIRST = 0,
  parameter int KEEP_NUM   = 336,
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 16
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_di,
  output logic              frame_ready,
  input  logic              frame_release,
  output logic [7:0]        frame_cnt,
  output logic              err_tlast
);

  localparam int BIN_W = $clog2(FFT_LEN);

  typedef enum logic {
    S_FILL,
    S_HOLD
  } state_e;

  state_e              state_q, state_d;
  logic [BIN_W-1:0]    bin_cnt_q, bin_cnt_d;
  logic                done_q, done_d;
  logic                en_q, en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   di_q, di_d;
  logic                ready_q, ready_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                err_q, err_d;

  logic                accept;
  logic                is_last_bin;
  logic [BIN_W:0]      bin_off;
  logic                in_keep;
  logic                tlast_early;
  logic                tlast_missing;

  assign s_axis_tready = (state_q == S_FILL);
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign is_last_bin   = (bin_cnt_q == BIN_W'(FFT_LEN - 1));

  // One extra bit so a bin below KEEP_FIRST shows up as a negative offset.
  assign bin_off = {1'b0, bin_cnt_q} - (BIN_W + 1)'(KEEP_FIRST);
  assign in_keep = !bin_off[BIN_W] && (bin_off < (BIN_W + 1)'(KEEP_NUM));

`ifdef HERMRMV_TLAST_CHECK_EN
  assign tlast_early   = accept & s_axis_tlast & ~is_last_bin;
  assign tlast_missing = accept & ~s_axis_tlast & is_last_bin;
`else
  // Framing is by count only; tlast is deliberately unused in this build.
  logic tlast_unused;
  assign tlast_unused  = s_axis_tlast;
  assign tlast_early   = 1'b0;
  assign tlast_missing = 1'b0;
`endif

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    bin_cnt_d = bin_cnt_q;
    done_d    = 1'b0;
    en_d      = 1'b0;
    addr_d    = addr_q;
    di_d      = di_q;
    ready_d   = ready_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;

    unique case (state_q)
      S_FILL: begin
        if (accept) begin
          if (in_keep) begin
            en_d   = 1'b1;
            addr_d = bin_off[ADDR_W-1:0];
            di_d   = s_axis_tdata;
          end
          err_d = tlast_early | tlast_missing;
          if (is_last_bin) begin
            bin_cnt_d = '0;
            done_d    = 1'b1;
            state_d   = S_HOLD;
          end else if (tlast_early) begin
            bin_cnt_d = '0;
          end else begin
            bin_cnt_d = bin_cnt_q + 1'b1;
          end
        end
      end

      S_HOLD: begin
        // done_q delays the ready flag so it trails the final write strobe by a cycle.
        if (done_q) begin
          ready_d = 1'b1;
          cnt_d   = cnt_q + 8'd1;
        end else if (frame_release && ready_q) begin
          ready_d = 1'b0;
          state_d = S_FILL;
        end
      end

      default: state_d = S_FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= S_FILL;
      bin_cnt_q <= '0;
      done_q    <= 1'b0;
      en_q      <= 1'b0;
      addr_q    <= '0;
      di_q      <= '0;
      ready_q   <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_cnt_q <= bin_cnt_d;
      done_q    <= done_d;
      en_q      <= en_d;
      addr_q    <= addr_d;
      di_q      <= di_d;
      ready_q   <= ready_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign bram_en     = en_q;
  assign bram_we     = en_q;
  assign bram_addr   = addr_q;
  assign bram_di     = di_q;
  assign frame_ready = ready_q;
  assign frame_cnt   = cnt_q;
  assign err_tlast   = err_q;

  a_ready_only_in_hold : assert property (@(posedge clk) disable iff (!aresetn)
    frame_ready |-> (state_q == S_HOLD));

  a_bin_in_range : assert property (@(posedge clk) disable iff (!aresetn)
    bin_cnt_q <= BIN_W'(FFT_LEN - 1));

  a_no_write_in_hold : assert property (@(posedge clk) disable iff (!aresetn)
    (state_q == S_HOLD && !done_q) |-> !en_d);

endmodule

// File: tb/tb_hermitian_rmv_bram_writer.sv
// Scoreboard bench for hermitian_rmv_bram_writer: the driver queues expected buffer writes,
// a negedge monitor pops and compares them whenever the write strobe is up.
module tb_hermitian_rmv_bram_writer;

  localparam int FFT_LEN  = 672;
  localparam int KEEP_NUM = 336;
  localparam int ADDR_W   = 9;
  localparam int DATA_W   = 16;
  localparam int PERIOD   = 10;

  logic              clk = 1'b0;
  logic              aresetn = 1'b0;
  logic [DATA_W-1:0] s_axis_tdata = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tlast = 1'b0;
  logic              s_axis_tready;
  logic              bram_en;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_di;
  logic              frame_ready;
  logic              frame_release = 1'b0;
  logic [7:0]        frame_cnt;
  logic              err_tlast;

  hermitian_rmv_bram_writer dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .bram_en       (bram_en),
    .bram_we       (bram_we),
    .bram_addr     (bram_addr),
    .bram_di       (bram_di),
    .frame_ready   (frame_ready),
    .frame_release (frame_release),
    .frame_cnt     (frame_cnt),
    .err_tlast     (err_tlast)
  );

  always #(PERIOD / 2) clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t sb_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  bit  gap_mode = 1'b0;
  bit  have_prev = 1'b0;
  time last_wr_t = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: compares every write strobe against the head of the expected queue.
  always @(negedge clk) begin
    if (aresetn) begin
      check("we_equals_en", bram_we, bram_en);
      if (bram_en) begin
        if (sb_q.size() == 0) begin
          check("unexpected_write_queue_size", sb_q.size(), 1);
        end else begin
          wr_t e;
          e = sb_q.pop_front();
          check("write_addr", bram_addr, e.addr);
          check("write_data", bram_di, e.data);
        end
        if (gap_mode && have_prev) check("strobe_spacing", 32'($time - last_wr_t), 2 * PERIOD);
        have_prev = 1'b1;
        last_wr_t = $time;
      end
    end
  end

  // Presents one sample and returns on the negedge after it is accepted.
  task automatic push(input int bin, input logic last);
    int guard;
    guard = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = DATA_W'(bin);
    s_axis_tlast  = last;
    while (!s_axis_tready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!s_axis_tready) begin
      check("accept_timeout_tready", s_axis_tready, 1);
      return;
    end
    if (bin < KEEP_NUM) sb_q.push_back({ADDR_W'(bin), DATA_W'(bin)});
    @(negedge clk);
  endtask

  task automatic idle();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_bins(input int first_b, input int last_b, input bit gap, input int tlast_bin);
    for (int b = first_b; b <= last_b; b++) begin
      push(b, b == tlast_bin);
      if (gap && b != last_b) idle();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // Called on the negedge right after the last-bin accept; a premature release is also tried.
  task automatic frame_done(input int exp_cnt);
    check("tready_low_in_hold", s_axis_tready, 0);
    check("frame_ready_not_early", frame_ready, 0);
    check("frame_cnt_before", frame_cnt, 8'(exp_cnt - 1));
    check("err_tlast_clean_frame", err_tlast, 0);
    frame_release = 1'b1;
    @(negedge clk);
    frame_release = 1'b0;
    check("frame_ready_rise", frame_ready, 1);
    check("frame_cnt_after", frame_cnt, exp_cnt);
    @(negedge clk);
    check("early_release_ignored_ready", frame_ready, 1);
    check("early_release_ignored_tready", s_axis_tready, 0);
  endtask

  task automatic release_buf();
    frame_release = 1'b1;
    @(negedge clk);
    frame_release = 1'b0;
    check("frame_ready_cleared", frame_ready, 0);
    check("tready_after_release", s_axis_tready, 1);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_tready"}, s_axis_tready, 1);
    check({tag, "_en"}, bram_en, 0);
    check({tag, "_we"}, bram_we, 0);
    check({tag, "_addr"}, bram_addr, 0);
    check({tag, "_di"}, bram_di, 0);
    check({tag, "_frame_ready"}, frame_ready, 0);
    check({tag, "_frame_cnt"}, frame_cnt, 0);
    check({tag, "_err_tlast"}, err_tlast, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset_checks("por");
    aresetn = 1'b1;
    @(negedge clk);

    // Continuous frame, data = bin index.
    send_bins(0, FFT_LEN - 1, 1'b0, FFT_LEN - 1);
    frame_done(1);

    // tvalid held high while holding: must not be accepted.
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 16'hdead;
    repeat (8) begin
      @(negedge clk);
      check("tready_hold_tvalid_high", s_axis_tready, 0);
    end
    release_buf();

    // Gapped frame starts right after release; its bin 0 must land at addr 0.
    gap_mode  = 1'b1;
    have_prev = 1'b0;
    send_bins(0, FFT_LEN - 1, 1'b1, FFT_LEN - 1);
    gap_mode  = 1'b0;
    frame_done(2);
    release_buf();

    // tlast on bin 100.
    send_bins(0, 100, 1'b0, 100);
`ifdef HERMRMV_TLAST_CHECK_EN
    check("err_tlast_pulse", err_tlast, 1);
    idle();
    check("err_tlast_one_cycle", err_tlast, 0);
    check("no_ready_after_resync", frame_ready, 0);
    check("tready_after_resync", s_axis_tready, 1);
    send_bins(0, FFT_LEN - 1, 1'b0, FFT_LEN - 1);
    frame_done(3);
`else
    check("err_tlast_tied_low", err_tlast, 0);
    idle();
    send_bins(101, FFT_LEN - 1, 1'b0, FFT_LEN - 1);
    frame_done(3);
`endif
    release_buf();

    // Reset at bin 200, then a clean frame.
    send_bins(0, 199, 1'b0, -1);
    @(negedge clk);
    aresetn = 1'b0;
    #1;
    reset_checks("midrun");
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    check("no_ready_after_partial", frame_ready, 0);
    send_bins(0, FFT_LEN - 1, 1'b0, FFT_LEN - 1);
    frame_done(1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
